// File: rtl/rvj1_dram_arbiter.sv
// rvj1_dram_arbiter: round-robin arbiter between the jedro_1 core data port and the
// Caravel Wishbone host for the shared data-memory port, with range check and timeout.
module rvj1_dram_arbiter #(
    parameter logic [31:0] MEM_BASE      = 32'h3000_4000,
    parameter int unsigned MEM_SIZE_LOG2 = 12,
    parameter int unsigned TIMEOUT       = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    // core data port
    input  logic        c_stb,
    input  logic [3:0]  c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic [31:0] c_rdata,
    output logic        c_ack,
    output logic        c_err,
    // host Wishbone port
    input  logic        h_cyc,
    input  logic        h_stb,
    input  logic        h_we,
    input  logic [3:0]  h_sel,
    input  logic [31:0] h_addr,
    input  logic [31:0] h_wdata,
    output logic [31:0] h_rdata,
    output logic        h_ack,
    // memory port
    output logic        m_stb,
    output logic [3:0]  m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    input  logic        m_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    logic [1:0]       state_q,   state_d;
    logic             last_q,    last_d;
    logic             owner_q,   owner_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             drop_q,    drop_d;

    logic             m_stb_q,   m_stb_d;
    logic [3:0]       m_we_q,    m_we_d;
    logic [31:0]      m_addr_q,  m_addr_d;
    logic [31:0]      m_wdata_q, m_wdata_d;
    logic             c_ack_q,   c_ack_d;
    logic             c_err_q,   c_err_d;
    logic [31:0]      c_rdata_q, c_rdata_d;
    logic             h_ack_q,   h_ack_d;
    logic [31:0]      h_rdata_q, h_rdata_d;

    logic             c_req_c;
    logic             h_req_c;
    logic             grant_host_c;
    logic [31:0]      sel_addr_c;
    logic [31:0]      sel_wdata_c;
    logic [3:0]       sel_we_c;
    logic [31:0]      offset_c;
    logic             in_range_c;
    logic             timeout_c;

    // Request decode, round-robin pick and range check of the candidate address
    always_comb begin
        c_req_c      = c_stb;
        h_req_c      = h_cyc & h_stb;
        grant_host_c = h_req_c & (~c_req_c | (last_q == OWN_CORE));
        sel_addr_c   = grant_host_c ? h_addr  : c_addr;
        sel_wdata_c  = grant_host_c ? h_wdata : c_wdata;
        sel_we_c     = grant_host_c ? (h_we ? h_sel : 4'b0000) : c_we;
        offset_c     = sel_addr_c - MEM_BASE;
        in_range_c   = ((offset_c >> MEM_SIZE_LOG2) == 32'd0);
        timeout_c    = (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        drop_d    = drop_q;
        m_stb_d   = 1'b0;
        m_we_d    = 4'b0000;
        m_addr_d  = 32'd0;
        m_wdata_d = 32'd0;
        c_ack_d   = 1'b0;
        c_err_d   = 1'b0;
        c_rdata_d = c_rdata_q;
        h_ack_d   = 1'b0;
        h_rdata_d = h_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (c_req_c | h_req_c) begin
                    owner_d = grant_host_c ? OWN_HOST : OWN_CORE;
                    last_d  = grant_host_c ? OWN_HOST : OWN_CORE;
                    cnt_d   = '0;
                    drop_d  = 1'b0;
                    if (in_range_c) begin
                        state_d   = S_BUSY;
                        m_stb_d   = 1'b1;
                        m_we_d    = sel_we_c;
                        m_addr_d  = sel_addr_c;
                        m_wdata_d = sel_wdata_c;
                    end else begin
                        // out of window: answer with an error, never touch memory
                        state_d = S_DONE;
                        if (grant_host_c) begin
                            h_ack_d   = 1'b1;
                            h_rdata_d = 32'd0;
                        end else begin
                            c_err_d   = 1'b1;
                            c_rdata_d = 32'd0;
                        end
                    end
                end
            end

            S_BUSY: begin
                cnt_d  = cnt_q + CNT_W'(1);
                drop_d = drop_q | ((owner_q == OWN_HOST) & ~h_cyc);
                if (m_err | m_ack | timeout_c) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    if (owner_q == OWN_CORE) begin
                        c_ack_d   = m_ack & ~m_err;
                        c_err_d   = ~(m_ack & ~m_err);
                        c_rdata_d = (m_ack & ~m_err) ? m_rdata : 32'd0;
                    end else if (~drop_d) begin
                        h_ack_d   = 1'b1;
                        h_rdata_d = (m_ack & ~m_err) ? m_rdata : 32'd0;
                    end
                end else begin
                    m_stb_d   = 1'b1;
                    m_we_d    = m_we_q;
                    m_addr_d  = m_addr_q;
                    m_wdata_d = m_wdata_q;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access without a response
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= S_IDLE;
            last_q    <= OWN_HOST;
            owner_q   <= OWN_CORE;
            cnt_q     <= '0;
            drop_q    <= 1'b0;
            m_stb_q   <= 1'b0;
            m_we_q    <= 4'b0000;
            m_addr_q  <= 32'd0;
            m_wdata_q <= 32'd0;
            c_ack_q   <= 1'b0;
            c_err_q   <= 1'b0;
            c_rdata_q <= 32'd0;
            h_ack_q   <= 1'b0;
            h_rdata_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
            m_stb_q   <= m_stb_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            c_ack_q   <= c_ack_d;
            c_err_q   <= c_err_d;
            c_rdata_q <= c_rdata_d;
            h_ack_q   <= h_ack_d;
            h_rdata_q <= h_rdata_d;
        end
    end

    assign m_stb   = m_stb_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign c_ack   = c_ack_q;
    assign c_err   = c_err_q;
    assign c_rdata = c_rdata_q;
    assign h_ack   = h_ack_q;
    assign h_rdata = h_rdata_q;

endmodule

// File: tb/tb_rvj1_dram_arbiter.sv
// Directed bench for rvj1_dram_arbiter; the bench plays the memory by hand.
module tb_rvj1_dram_arbiter;

    logic        clk_i;
    logic        rstn_i;
    logic        c_stb;
    logic [3:0]  c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [31:0] c_rdata;
    logic        c_ack;
    logic        c_err;
    logic        h_cyc;
    logic        h_stb;
    logic        h_we;
    logic [3:0]  h_sel;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    logic [31:0] h_rdata;
    logic        h_ack;
    logic        m_stb;
    logic [3:0]  m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        m_err;

    int checks   = 0;
    int failures = 0;

    rvj1_dram_arbiter dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .c_stb   (c_stb),
        .c_we    (c_we),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_rdata (c_rdata),
        .c_ack   (c_ack),
        .c_err   (c_err),
        .h_cyc   (h_cyc),
        .h_stb   (h_stb),
        .h_we    (h_we),
        .h_sel   (h_sel),
        .h_addr  (h_addr),
        .h_wdata (h_wdata),
        .h_rdata (h_rdata),
        .h_ack   (h_ack),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack),
        .m_err   (m_err)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int seq [3];
        int nacks;
        int dbl;
        int n;
        int stray;

        rstn_i = 1'b0;
        c_stb = 1'b0; c_we = 4'b0; c_addr = 32'd0; c_wdata = 32'd0;
        h_cyc = 1'b0; h_stb = 1'b0; h_we = 1'b0; h_sel = 4'b0; h_addr = 32'd0; h_wdata = 32'd0;
        m_rdata = 32'd0; m_ack = 1'b0; m_err = 1'b0;
        seq = '{default: -1};

        // reset state
        tick(); tick();
        chk("rst_m_stb",   32'(m_stb),   32'd0);
        chk("rst_c_ack",   32'(c_ack),   32'd0);
        chk("rst_c_err",   32'(c_err),   32'd0);
        chk("rst_h_ack",   32'(h_ack),   32'd0);
        chk("rst_c_rdata", c_rdata,      32'd0);
        chk("rst_m_addr",  m_addr,       32'd0);
        rstn_i = 1'b1;
        tick();

        // 1: core read, zero-wait memory
        c_stb = 1'b1; c_we = 4'b0000; c_addr = 32'h3000_4010;
        tick();
        chk("t1_m_stb",  32'(m_stb), 32'd1);
        chk("t1_m_addr", m_addr,     32'h3000_4010);
        chk("t1_m_we",   32'(m_we),  32'd0);
        chk("t1_c_ack_early", 32'(c_ack), 32'd0);
        m_ack = 1'b1; m_rdata = 32'hCAFE_F00D;
        tick();
        m_ack = 1'b0; c_stb = 1'b0;
        chk("t1_m_stb_off", 32'(m_stb), 32'd0);
        chk("t1_m_addr_off", m_addr,    32'd0);
        chk("t1_c_ack",   32'(c_ack),   32'd1);
        chk("t1_c_err",   32'(c_err),   32'd0);
        chk("t1_c_rdata", c_rdata,      32'hCAFE_F00D);
        tick();
        chk("t1_c_ack_pulse", 32'(c_ack), 32'd0);
        chk("t1_c_rdata_hold", c_rdata,   32'hCAFE_F00D);

        // 2: host byte-select write
        h_cyc = 1'b1; h_stb = 1'b1; h_we = 1'b1; h_sel = 4'b0011;
        h_addr = 32'h3000_4004; h_wdata = 32'h1234_5678;
        tick();
        chk("t2_m_stb",   32'(m_stb), 32'd1);
        chk("t2_m_we",    32'(m_we),  32'b0011);
        chk("t2_m_wdata", m_wdata,    32'h1234_5678);
        chk("t2_m_addr",  m_addr,     32'h3000_4004);
        m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
        tick();
        m_ack = 1'b0; h_cyc = 1'b0; h_stb = 1'b0; h_we = 1'b0;
        chk("t2_h_ack",   32'(h_ack), 32'd1);
        chk("t2_h_rdata", h_rdata,    32'hDEAD_BEEF);
        chk("t2_c_ack",   32'(c_ack), 32'd0);
        tick();
        chk("t2_h_ack_pulse", 32'(h_ack), 32'd0);

        // 3: both requesters held; grants must alternate core, host, core
        c_stb = 1'b1; c_addr = 32'h3000_4100; c_we = 4'b0000;
        h_cyc = 1'b1; h_stb = 1'b1; h_we = 1'b0; h_addr = 32'h3000_4200;
        m_rdata = 32'h5555_AAAA;
        nacks = 0; dbl = 0;
        for (int i = 0; i < 40 && nacks < 3; i++) begin
            m_ack = m_stb;
            tick();
            if (c_ack && h_ack) dbl++;
            if (c_ack) begin seq[nacks] = 0; nacks++; end
            else if (h_ack) begin seq[nacks] = 1; nacks++; end
        end
        m_ack = 1'b0; c_stb = 1'b0; h_cyc = 1'b0; h_stb = 1'b0;
        chk("t3_nacks",  32'(nacks), 32'd3);
        chk("t3_first",  32'(seq[0]), 32'd0);
        chk("t3_second", 32'(seq[1]), 32'd1);
        chk("t3_third",  32'(seq[2]), 32'd0);
        chk("t3_double", 32'(dbl),    32'd0);
        chk("t3_h_rdata", h_rdata,    32'h5555_AAAA);
        tick();

        // 4: out-of-range core read, then out-of-range host read
        c_stb = 1'b1; c_addr = 32'h3000_5000;
        tick();
        c_stb = 1'b0;
        chk("t4_c_err",   32'(c_err), 32'd1);
        chk("t4_c_ack",   32'(c_ack), 32'd0);
        chk("t4_m_stb",   32'(m_stb), 32'd0);
        chk("t4_c_rdata", c_rdata,    32'd0);
        tick();
        chk("t4_c_err_pulse", 32'(c_err), 32'd0);
        h_cyc = 1'b1; h_stb = 1'b1; h_we = 1'b0; h_addr = 32'h0000_0000;
        tick();
        h_cyc = 1'b0; h_stb = 1'b0;
        chk("t4_h_ack",   32'(h_ack), 32'd1);
        chk("t4_h_rdata", h_rdata,    32'd0);
        chk("t4_h_m_stb", 32'(m_stb), 32'd0);
        tick();

        // 5: memory never answers -> 16 strobe cycles then error
        c_stb = 1'b1; c_addr = 32'h3000_4020;
        tick();
        n = 0;
        while (m_stb && n < 40) begin
            n++;
            tick();
        end
        c_stb = 1'b0;
        chk("t5_stb_cycles", 32'(n),     32'd16);
        chk("t5_c_err",      32'(c_err), 32'd1);
        chk("t5_c_ack",      32'(c_ack), 32'd0);
        tick();
        // ack and err together: err wins
        c_stb = 1'b1; c_addr = 32'h3000_4024;
        tick();
        chk("t5b_m_stb", 32'(m_stb), 32'd1);
        m_ack = 1'b1; m_err = 1'b1; m_rdata = 32'h1111_2222;
        tick();
        m_ack = 1'b0; m_err = 1'b0; c_stb = 1'b0;
        chk("t5b_c_err",   32'(c_err), 32'd1);
        chk("t5b_c_ack",   32'(c_ack), 32'd0);
        chk("t5b_c_rdata", c_rdata,    32'd0);
        tick();

        // host abandons its cycle while memory is busy: no h_ack
        h_cyc = 1'b1; h_stb = 1'b1; h_we = 1'b0; h_addr = 32'h3000_4008;
        tick();
        chk("t5c_m_stb", 32'(m_stb), 32'd1);
        h_cyc = 1'b0; h_stb = 1'b0;
        m_ack = 1'b1; m_rdata = 32'h7777_8888;
        tick();
        m_ack = 1'b0;
        chk("t5c_h_ack",   32'(h_ack), 32'd0);
        chk("t5c_m_stb_off", 32'(m_stb), 32'd0);
        tick();

        // 6: reset in BUSY drops the strobe immediately and yields no response
        c_stb = 1'b1; c_addr = 32'h3000_4030;
        tick();
        chk("t6_m_stb_busy", 32'(m_stb), 32'd1);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("t6_m_stb_rst", 32'(m_stb), 32'd0);
        chk("t6_m_addr_rst", m_addr,    32'd0);
        c_stb = 1'b0;
        tick();
        rstn_i = 1'b1;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (c_ack || c_err || h_ack || m_stb) stray++;
        end
        chk("t6_no_stray", 32'(stray), 32'd0);
        c_stb = 1'b1; c_addr = 32'h3000_4040;
        tick();
        chk("t6_regrant_stb",  32'(m_stb), 32'd1);
        chk("t6_regrant_addr", m_addr,     32'h3000_4040);
        m_ack = 1'b1; m_rdata = 32'h0BAD_F00D;
        tick();
        m_ack = 1'b0; c_stb = 1'b0;
        chk("t6_c_ack",   32'(c_ack), 32'd1);
        chk("t6_c_rdata", c_rdata,    32'h0BAD_F00D);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
